// File: rtl/sprite_arb_pkg.sv
// Shared constants, tag type and index helpers for the sprite ROM arbiter.
package sprite_arb_pkg;

    localparam int N_REQ      = 3;
    localparam int REQ_BG     = 0;
    localparam int REQ_DINO   = 1;
    localparam int REQ_DANGER = 2;
    localparam int ROM_LAT    = 1;

    // One entry of the tag pipeline: which requester owns the read in flight.
    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } tag_t;

    // One-hot requester vector to index; an all-zero vector maps to 0.
    function automatic logic [1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'(REQ_BG);
        if (oh[REQ_DINO])   idx = 2'(REQ_DINO);
        if (oh[REQ_DANGER]) idx = 2'(REQ_DANGER);
        return idx;
    endfunction

    // Index to one-hot requester vector.
    function automatic logic [N_REQ-1:0] idx_to_oh(input logic [1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        case (idx)
            2'(REQ_DINO):   oh[REQ_DINO]   = 1'b1;
            2'(REQ_DANGER): oh[REQ_DANGER] = 1'b1;
            default:        oh[REQ_BG]     = 1'b1;
        endcase
        return oh;
    endfunction

    // Round-robin pointer after granting idx: the next requester goes first.
    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        return (idx == 2'(N_REQ - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select over the eligible vector.
// Default: round-robin starting at ptr_i. With SPRITE_ARB_FIXED_PRIO_EN
// defined it is a fixed-priority encoder: dino > danger > background.
module rr_pick
    import sprite_arb_pkg::*;
(
    input  logic [N_REQ-1:0] elig_i,
    input  logic [1:0]       ptr_i,
    output logic [N_REQ-1:0] win_o
);

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    // Fixed order; the pointer input is left unused in this build.
    always_comb begin
        win_o = '0;
        if (elig_i[REQ_DINO])        win_o[REQ_DINO]   = 1'b1;
        else if (elig_i[REQ_DANGER]) win_o[REQ_DANGER] = 1'b1;
        else if (elig_i[REQ_BG])     win_o[REQ_BG]     = 1'b1;
    end
`else
    int   idx;
    logic found;

    // Scan eligible requesters starting at the pointer, first hit wins.
    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (!found && elig_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM among background, dino and danger
// generators. One grant per cycle; read data returns 3 cycles after the
// request is eligible, tagged one-hot on rvalid, strictly in grant order.
// Optional build macro: SPRITE_ARB_FIXED_PRIO_EN (fixed priority, no pointer).
// Handshake: a requester holds req/addr until it sees its gnt bit; it is
// ineligible while its own gnt shows, so a held req is never double granted.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [2:0]        gnt,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] rdata,
    output logic [2:0]        rvalid
);

    localparam int TAG_DEPTH = ROM_LAT + 1;

    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    tag_t              tag_q [TAG_DEPTH];
    tag_t              tag_d;
    logic [1:0]        ptr_q;

    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  win;
    logic [1:0]        win_idx;
    logic              any_elig;

    assign elig     = req & ~gnt_q;
    assign any_elig = |elig;
    assign win_idx  = oh_to_idx(win);

    rr_pick u_pick (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .win_o  (win)
    );

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    assign ptr_q = 2'd0;
`else
    logic [1:0] ptr_d;

    // Pointer moves past the winner only when a grant is issued.
    always_comb begin
        ptr_d = ptr_q;
        if (any_elig) ptr_d = next_ptr(win_idx);
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (!rst) ptr_q <= 2'd0;
        else      ptr_q <= ptr_d;
    end
`endif

    // Grant, ROM drive and data return next-state.
    always_comb begin
        gnt_d      = win;
        rom_en_d   = any_elig;
        rom_addr_d = rom_addr_q;
        if (any_elig) begin
            case (win_idx)
                2'(REQ_DINO):   rom_addr_d = addr1;
                2'(REQ_DANGER): rom_addr_d = addr2;
                default:        rom_addr_d = addr0;
            endcase
        end
        tag_d.vld = any_elig;
        tag_d.idx = win_idx;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        if (tag_q[TAG_DEPTH-1].vld) begin
            rvalid_d = idx_to_oh(tag_q[TAG_DEPTH-1].idx);
            rdata_d  = rom_data;
        end
    end

    // State registers; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
            for (int s = 0; s < TAG_DEPTH; s++) tag_q[s] <= '0;
        end else begin
            gnt_q      <= gnt_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            tag_q[0]   <= tag_d;
            for (int s = 1; s < TAG_DEPTH; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    assign gnt      = gnt_q;
    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized bench for sprite_rom_arbiter with a request-level reference
// model: last-granted round-robin (or fixed order), a ROM content function
// and an expected-data queue for the in-order returns.
module tb_sprite_rom_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 12;

    logic              clk;
    logic              rst;
    logic [2:0]        req;
    logic [ADDR_W-1:0] addr0, addr1, addr2;
    logic [2:0]        gnt;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] rdata;
    logic [2:0]        rvalid;

    int total_cnt;
    int bad_cnt;

    // Stimulus controls
    int                prob [3];
    logic              fixed_addr_en;
    logic [ADDR_W-1:0] fixed_addr;
    logic              rst_cmd;
    logic [2:0]        act;
    logic [ADDR_W-1:0] r_addr [3];

    // Reference model state (expected DUT outputs for the coming cycle)
    logic [2:0]        e_gnt, e_rvalid, g1;
    logic              e_rom_en;
    logic [ADDR_W-1:0] e_rom_addr;
    logic [DATA_W-1:0] e_rdata;
    int                m_last;
    logic [DATA_W-1:0] exp_q [$];
    logic [2:0]        prev_dut_gnt;

    sprite_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr0    (addr0),
        .addr1    (addr1),
        .addr2    (addr2),
        .gnt      (gnt),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rdata    (rdata),
        .rvalid   (rvalid)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents as a pure function of the address
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        if (a == 16'h0123) return 12'hABC;
        t = (a * 16'd7) ^ (a >> 5) ^ 16'h00A5;
        return t[DATA_W-1:0];
    endfunction

    // Synchronous ROM: data one cycle after rom_en
    initial rom_data = '0;
    always @(posedge clk) if (rom_en) rom_data <= rom_word(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s at %0t: got=%h want=%h", tag, $time, got, want);
        end
    endtask

    // Winner under the arbitration rules, given the eligible set
    function automatic int pick(input logic [2:0] elig, input int last);
        int order [3];
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        order = '{1, 2, 0};
`else
        for (int k = 0; k < 3; k++) order[k] = (last + 1 + k) % 3;
`endif
        for (int k = 0; k < 3; k++) if (elig[order[k]]) return order[k];
        return -1;
    endfunction

    // One clock: check outputs, move requesters, advance the model
    task automatic step();
        logic [2:0] elig;
        int         w;
        @(posedge clk);
        #1;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("rom_en", 32'(rom_en), 32'(e_rom_en));
        check("rom_addr", 32'(rom_addr), 32'(e_rom_addr));
        check("rvalid", 32'(rvalid), 32'(e_rvalid));
        check("rdata", 32'(rdata), 32'(e_rdata));
        check("no_regrant", 32'(gnt & prev_dut_gnt), 32'd0);
        prev_dut_gnt = gnt;

        for (int i = 0; i < 3; i++) begin
            if (e_gnt[i]) act[i] = 1'b0;
            if (!act[i] && ($urandom_range(0, 99) < prob[i])) begin
                act[i]    = 1'b1;
                r_addr[i] = fixed_addr_en ? fixed_addr : ADDR_W'($urandom_range(0, 65535));
            end
        end
        req   = act;
        addr0 = r_addr[0];
        addr1 = r_addr[1];
        addr2 = r_addr[2];
        rst   = rst_cmd;

        if (!rst_cmd) begin
            e_gnt      = '0;
            e_rom_en   = 1'b0;
            e_rom_addr = '0;
            e_rdata    = '0;
            e_rvalid   = '0;
            g1         = '0;
            m_last     = 2;
            exp_q.delete();
        end else begin
            e_rvalid = g1;
            if (g1 != 3'b000) begin
                if (exp_q.size() == 0) check("exp_q_empty", 32'd1, 32'd0);
                else e_rdata = exp_q.pop_front();
            end
            g1   = e_gnt;
            elig = req & ~e_gnt;
            w    = pick(elig, m_last);
            if (w >= 0) begin
                e_gnt      = 3'(1 << w);
                e_rom_en   = 1'b1;
                e_rom_addr = r_addr[w];
                m_last     = w;
                exp_q.push_back(rom_word(r_addr[w]));
            end else begin
                e_gnt    = '0;
                e_rom_en = 1'b0;
            end
        end
    endtask

    task automatic set_prob(input int p0, input int p1, input int p2);
        prob[0] = p0;
        prob[1] = p1;
        prob[2] = p2;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst = 1'b0; rst_cmd = 1'b0;
        req = '0; addr0 = '0; addr1 = '0; addr2 = '0;
        act = '0;
        for (int i = 0; i < 3; i++) r_addr[i] = '0;
        fixed_addr_en = 1'b0; fixed_addr = '0;
        set_prob(0, 0, 0);
        e_gnt = '0; e_rom_en = 1'b0; e_rom_addr = '0; e_rdata = '0; e_rvalid = '0;
        g1 = '0; m_last = 2; prev_dut_gnt = '0;

        // Reset state
        repeat (3) step();
        rst_cmd = 1'b1;
        repeat (2) step();

        // Single dino request to 0x0123
        fixed_addr_en = 1'b1; fixed_addr = 16'h0123;
        set_prob(0, 100, 0);
        step();
        set_prob(0, 0, 0);
        repeat (6) step();
        fixed_addr_en = 1'b0;

        // All three requesting continuously
        set_prob(100, 100, 100);
        repeat (12) step();

        // Reset with reads in flight, requests kept up
        rst_cmd = 1'b0;
        step();
        rst_cmd = 1'b1;
        repeat (8) step();

        // Drain then idle
        set_prob(0, 0, 0);
        repeat (4) step();
        repeat (10) step();

        // Randomized traffic with occasional resets
        for (int blk = 0; blk < 25; blk++) begin
            set_prob($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(0, 100));
            for (int c = 0; c < 20; c++) begin
                rst_cmd = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
                step();
            end
        end
        rst_cmd = 1'b1;
        set_prob(0, 0, 0);
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
